// File: rtl/fifo_addr_ctrl_if.sv
// Request/grant and status bundle between a requester and fifo_addr_ctrl.
// master: requester drives en/flush/we/re/clr_err; slave: controller drives grants, pointers and flags.
interface fifo_addr_ctrl_if #(
    parameter int AW = 32,
    parameter int CW = 5
);
    logic          en;
    logic          flush;
    logic          we;
    logic          re;
    logic          clr_err;
    logic          we_g;
    logic          re_g;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic          ovf;
    logic          udf;

    modport master (
        output en, flush, we, re, clr_err,
        input  we_g, re_g, wr_addr, rd_addr, count,
        input  empty, full, almost_empty, almost_full, ovf, udf
    );

    modport slave (
        input  en, flush, we, re, clr_err,
        output we_g, re_g, wr_addr, rd_addr, count,
        output empty, full, almost_empty, almost_full, ovf, udf
    );
endinterface

// File: rtl/fifo_addr_ctrl.sv
// Read/write address and occupancy controller for a circular buffer of any depth.
// Ports: clk, rst (async active-low), bus (slave: requests in; grants, pointers, count, flags out).
module fifo_addr_ctrl #(
    parameter int AW     = 32,
    parameter int DEPTH  = 16,
    parameter int CW     = $clog2(DEPTH + 1),
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic clk,
    input  logic rst,
    fifo_addr_ctrl_if.slave bus
);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULLC = CW'(DEPTH);
    localparam logic [CW-1:0] AFC   = CW'(AF_LVL);
    localparam logic [CW-1:0] AEC   = CW'(AE_LVL);

    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          udf_q;
    logic          act;
    logic          we_g;
    logic          re_g;
    logic          empty;
    logic          full;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULLC);
    assign act   = bus.en & ~bus.flush;
    assign re_g  = act & bus.re & ~empty;
    // a read in the same cycle frees the slot, so a full buffer still takes the write
    assign we_g  = act & bus.we & (~full | re_g);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (bus.en) begin
            if (bus.flush) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (we_g) wr_q <= nxt(wr_q);
                if (re_g) rd_q <= nxt(rd_q);
                unique case (1'b1)
                    we_g & ~re_g: cnt_q <= cnt_q + 1'b1;
                    re_g & ~we_g: cnt_q <= cnt_q - 1'b1;
                    default:      cnt_q <= cnt_q;
                endcase
            end
            // clear first so a same-cycle refusal wins
            if (bus.clr_err) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end
            if (!bus.flush && bus.we && !we_g) ovf_q <= 1'b1;
            if (!bus.flush && bus.re && !re_g) udf_q <= 1'b1;
        end
    end

    assign bus.we_g         = we_g;
    assign bus.re_g         = re_g;
    assign bus.wr_addr      = wr_q;
    assign bus.rd_addr      = rd_q;
    assign bus.count        = cnt_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (cnt_q <= AEC);
    assign bus.almost_full  = (cnt_q >= AFC);
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;
endmodule
